// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and widths for the 4-stage 8-bit pipeline
package pipe_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int DATA_W     = 8;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALT     = 2'd3
   } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// rtl/pipeline_hazard_ctrl_fwd_unit.sv - EM-stage operand forwarding compare
// Ports:
//   wb_regwrite    - EM/WB register writes back this cycle
//   wb_write_addr  - EM/WB destination register
//   em_rs_addr     - rs address of the instruction in EM
//   em_rt_addr     - rt address of the instruction in EM
//   fwd_rs         - take rs operand from the WB result
//   fwd_rt         - take rt operand from the WB result
module fwd_unit
   import pipe_pkg::*;
(
   input  logic                  wb_regwrite,
   input  logic [REG_ADDR_W-1:0] wb_write_addr,
   input  logic [REG_ADDR_W-1:0] em_rs_addr,
   input  logic [REG_ADDR_W-1:0] em_rt_addr,
   output logic                  fwd_rs,
   output logic                  fwd_rt
);

   // Register 0 is an ordinary register in this machine, so no zero check.
   assign fwd_rs = wb_regwrite && (wb_write_addr == em_rs_addr);
   assign fwd_rt = wb_regwrite && (wb_write_addr == em_rt_addr);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - global stall/flush/forward/halt sequencing for the pipeline
// Ports:
//   clk_i, rst_n_i          - clock, synchronous active-low reset
//   em_memread_i/memwrite_i - data-memory access of the instruction in EM
//   em_done_i               - instruction in EM is the done marker
//   em_rs_addr_i/rt_addr_i  - EM operand addresses
//   wb_regwrite_i, wb_write_addr_i - EM/WB writeback
//   mem_ready_i             - data memory completes this cycle
//   mem_req_o               - data memory request strobe
//   stall_o, flush_o        - pipeline-register hold / ID/EM bubble
//   fwd_rs_o, fwd_rt_o      - EM operand forwarding selects
//   halt_o, mem_err_o       - retired / sticky memory timeout
//   stall_cnt_o             - saturating stall-cycle counter
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 15,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  em_memread_i,
   input  logic                  em_memwrite_i,
   input  logic                  em_done_i,
   input  logic [REG_ADDR_W-1:0] em_rs_addr_i,
   input  logic [REG_ADDR_W-1:0] em_rt_addr_i,
   input  logic                  wb_regwrite_i,
   input  logic [REG_ADDR_W-1:0] wb_write_addr_i,
   input  logic                  mem_ready_i,
   output logic                  mem_req_o,
   output logic                  stall_o,
   output logic                  flush_o,
   output logic                  fwd_rs_o,
   output logic                  fwd_rt_o,
   output logic                  halt_o,
   output logic                  mem_err_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   // The cycle in RUN that first sees the access unready counts as wait cycle 1,
   // so the timeout fires when the count would step from MEM_TIMEOUT-1 to MEM_TIMEOUT.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [7:0] DRAIN_LAST   = 8'(DRAIN_CYCLES - 1);

   state_t       state;
   logic [7:0]   wait_cnt;
   logic [7:0]   drain_cnt;
   logic         acc;
   logic         fwd_rs_raw;
   logic         fwd_rt_raw;

   assign acc = em_memread_i | em_memwrite_i;

   fwd_unit u_fwd (
      .wb_regwrite   (wb_regwrite_i),
      .wb_write_addr (wb_write_addr_i),
      .em_rs_addr    (em_rs_addr_i),
      .em_rt_addr    (em_rt_addr_i),
      .fwd_rs        (fwd_rs_raw),
      .fwd_rt        (fwd_rt_raw)
   );

   assign fwd_rs_o = rst_n_i & fwd_rs_raw;
   assign fwd_rt_o = rst_n_i & fwd_rt_raw;

   // While reset is held the pipeline must keep loading bubbles and never
   // issue a memory request, regardless of the state register contents.
   always_comb begin
      mem_req_o = 1'b0;
      stall_o   = 1'b0;
      flush_o   = 1'b0;
      if (!rst_n_i) begin
         flush_o = 1'b1;
      end else begin
         case (state)
            RUN: begin
               mem_req_o = acc;
               stall_o   = acc & ~mem_ready_i;
            end
            MEM_WAIT: begin
               mem_req_o = 1'b1;
               stall_o   = ~mem_ready_i;
            end
            DRAIN: begin
               flush_o = 1'b1;
            end
            HALT: begin
               stall_o = 1'b1;
               flush_o = 1'b1;
            end
            default: begin
               flush_o = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         drain_cnt   <= 8'd0;
         halt_o      <= 1'b0;
         mem_err_o   <= 1'b0;
         stall_cnt_o <= '0;
      end else begin
         // HALT holds stall for good; only hazard stalls are performance-relevant.
         if (stall_o && (state != HALT) && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);

         case (state)
            RUN: begin
               if (acc && !mem_ready_i) begin
                  if (MEM_TIMEOUT == 1) begin
                     mem_err_o <= 1'b1;
                     halt_o    <= 1'b1;
                     state     <= HALT;
                  end else begin
                     wait_cnt <= 8'd1;
                     state    <= MEM_WAIT;
                  end
               end else if (em_done_i) begin
                  drain_cnt <= 8'd0;
                  state     <= DRAIN;
               end
            end
            MEM_WAIT: begin
               // Ready is checked first so a late completion beats the timeout.
               if (mem_ready_i) begin
                  if (em_done_i) begin
                     drain_cnt <= 8'd0;
                     state     <= DRAIN;
                  end else begin
                     state <= RUN;
                  end
               end else if (wait_cnt >= TIMEOUT_LAST) begin
                  mem_err_o <= 1'b1;
                  halt_o    <= 1'b1;
                  state     <= HALT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DRAIN: begin
               if (drain_cnt >= DRAIN_LAST) begin
                  halt_o <= 1'b1;
                  state  <= HALT;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        em_memread_i, em_memwrite_i, em_done_i;
   logic [2:0]  em_rs_addr_i, em_rt_addr_i, wb_write_addr_i;
   logic        wb_regwrite_i, mem_ready_i;
   logic        mem_req_o, stall_o, flush_o, fwd_rs_o, fwd_rt_o, halt_o, mem_err_o;
   logic [15:0] stall_cnt_o;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .em_memread_i(em_memread_i), .em_memwrite_i(em_memwrite_i), .em_done_i(em_done_i),
      .em_rs_addr_i(em_rs_addr_i), .em_rt_addr_i(em_rt_addr_i),
      .wb_regwrite_i(wb_regwrite_i), .wb_write_addr_i(wb_write_addr_i),
      .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .stall_o(stall_o),
      .flush_o(flush_o), .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o),
      .halt_o(halt_o), .mem_err_o(mem_err_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clr_inputs();
      em_memread_i = 0; em_memwrite_i = 0; em_done_i = 0;
      em_rs_addr_i = 0; em_rt_addr_i = 0;
      wb_regwrite_i = 0; wb_write_addr_i = 0; mem_ready_i = 0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_n_i = 0;
      tick(); tick();
      rst_n_i = 1;
   endtask

   task automatic test_reset();
      clr_inputs();
      rst_n_i = 0;
      em_memread_i = 1; mem_ready_i = 0;
      wb_regwrite_i = 1; wb_write_addr_i = 3; em_rs_addr_i = 3; em_rt_addr_i = 3;
      tick(); tick();
      #1;
      total++; if (stall_o !== 1'b0)   begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_o); end
      total++; if (flush_o !== 1'b1)   begin bad++; $display("FAIL rst_flush got=%0b exp=1", flush_o); end
      total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_memreq got=%0b exp=0", mem_req_o); end
      total++; if (fwd_rs_o !== 1'b0 || fwd_rt_o !== 1'b0) begin bad++; $display("FAIL rst_fwd got=%0b%0b exp=00", fwd_rs_o, fwd_rt_o); end
      total++; if (halt_o !== 1'b0 || mem_err_o !== 1'b0) begin bad++; $display("FAIL rst_halt_err got=%0b%0b exp=00", halt_o, mem_err_o); end
      total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt_o); end
      clr_inputs();
      rst_n_i = 1;
   endtask

   task automatic test_zero_wait();
      do_reset();
      em_memread_i = 1; mem_ready_i = 1;
      #1;
      total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL zw_memreq got=%0b exp=1", mem_req_o); end
      total++; if (stall_o !== 1'b0)   begin bad++; $display("FAIL zw_stall got=%0b exp=0", stall_o); end
      tick();
      clr_inputs();
      tick();
      total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL zw_cnt got=%0d exp=0", stall_cnt_o); end
   endtask

   task automatic test_store_wait();
      do_reset();
      em_memwrite_i = 1; mem_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1) begin bad++; $display("FAIL sw_wait%0d stall/req got=%0b%0b exp=11", i, stall_o, mem_req_o); end
         tick();
      end
      mem_ready_i = 1;
      #1;
      total++; if (stall_o !== 1'b0 || mem_req_o !== 1'b1) begin bad++; $display("FAIL sw_ready stall/req got=%0b%0b exp=01", stall_o, mem_req_o); end
      tick();
      clr_inputs();
      #1;
      total++; if (stall_cnt_o !== 16'd3) begin bad++; $display("FAIL sw_cnt got=%0d exp=3", stall_cnt_o); end
      total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL sw_idle req/stall got=%0b%0b exp=00", mem_req_o, stall_o); end
      em_memread_i = 1; mem_ready_i = 1;
      #1;
      total++; if (mem_req_o !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("FAIL sw_run req/stall got=%0b%0b exp=10", mem_req_o, stall_o); end
      tick();
      clr_inputs();
   endtask

   task automatic test_forward();
      do_reset();
      wb_regwrite_i = 1; wb_write_addr_i = 5; em_rs_addr_i = 5; em_rt_addr_i = 2;
      #1;
      total++; if (fwd_rs_o !== 1'b1 || fwd_rt_o !== 1'b0) begin bad++; $display("FAIL fwd_rs5 got=%0b%0b exp=10", fwd_rs_o, fwd_rt_o); end
      wb_regwrite_i = 0;
      #1;
      total++; if (fwd_rs_o !== 1'b0 || fwd_rt_o !== 1'b0) begin bad++; $display("FAIL fwd_nowr got=%0b%0b exp=00", fwd_rs_o, fwd_rt_o); end
      wb_regwrite_i = 1; wb_write_addr_i = 6; em_rs_addr_i = 1; em_rt_addr_i = 6;
      #1;
      total++; if (fwd_rs_o !== 1'b0 || fwd_rt_o !== 1'b1) begin bad++; $display("FAIL fwd_rt6 got=%0b%0b exp=01", fwd_rs_o, fwd_rt_o); end
      wb_write_addr_i = 0; em_rs_addr_i = 0; em_rt_addr_i = 0;
      #1;
      total++; if (fwd_rs_o !== 1'b1 || fwd_rt_o !== 1'b1) begin bad++; $display("FAIL fwd_r0 got=%0b%0b exp=11", fwd_rs_o, fwd_rt_o); end
      clr_inputs();
   endtask

   task automatic test_drain();
      do_reset();
      em_done_i = 1;
      #1;
      total++; if (flush_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL dr_run flush/stall got=%0b%0b exp=00", flush_o, stall_o); end
      tick();
      em_done_i = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (flush_o !== 1'b1 || stall_o !== 1'b0 || halt_o !== 1'b0 || mem_req_o !== 1'b0) begin bad++; $display("FAIL dr_cyc%0d flush/stall/halt/req got=%0b%0b%0b%0b exp=1000", i, flush_o, stall_o, halt_o, mem_req_o); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         total++; if (halt_o !== 1'b1 || stall_o !== 1'b1 || flush_o !== 1'b1) begin bad++; $display("FAIL dr_halt%0d halt/stall/flush got=%0b%0b%0b exp=111", i, halt_o, stall_o, flush_o); end
         tick();
      end
      total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL dr_cnt got=%0d exp=0", stall_cnt_o); end
      rst_n_i = 0;
      tick();
      rst_n_i = 1;
      #1;
      total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL dr_rst_halt got=%0b exp=0", halt_o); end
   endtask

   task automatic test_done_with_wait();
      do_reset();
      em_memread_i = 1; em_done_i = 1; mem_ready_i = 0;
      #1;
      total++; if (stall_o !== 1'b1 || flush_o !== 1'b0) begin bad++; $display("FAIL dw_wait stall/flush got=%0b%0b exp=10", stall_o, flush_o); end
      tick();
      mem_ready_i = 1;
      #1;
      total++; if (stall_o !== 1'b0 || mem_req_o !== 1'b1) begin bad++; $display("FAIL dw_ready stall/req got=%0b%0b exp=01", stall_o, mem_req_o); end
      tick();
      clr_inputs();
      #1;
      total++; if (flush_o !== 1'b1 || halt_o !== 1'b0) begin bad++; $display("FAIL dw_drain flush/halt got=%0b%0b exp=10", flush_o, halt_o); end
      tick(); tick();
      total++; if (halt_o !== 1'b1 || mem_err_o !== 1'b0) begin bad++; $display("FAIL dw_halt halt/err got=%0b%0b exp=10", halt_o, mem_err_o); end
      total++; if (stall_cnt_o !== 16'd1) begin bad++; $display("FAIL dw_cnt got=%0d exp=1", stall_cnt_o); end
   endtask

   task automatic test_timeout();
      do_reset();
      em_memread_i = 1; mem_ready_i = 0;
      for (int i = 0; i < 15; i++) begin
         #1;
         total++; if (stall_o !== 1'b1 || halt_o !== 1'b0 || mem_err_o !== 1'b0) begin bad++; $display("FAIL to_wait%0d stall/halt/err got=%0b%0b%0b exp=100", i, stall_o, halt_o, mem_err_o); end
         tick();
      end
      total++; if (mem_err_o !== 1'b1 || halt_o !== 1'b1) begin bad++; $display("FAIL to_err err/halt got=%0b%0b exp=11", mem_err_o, halt_o); end
      total++; if (stall_cnt_o !== 16'd15) begin bad++; $display("FAIL to_cnt got=%0d exp=15", stall_cnt_o); end
      clr_inputs();
      tick();
      total++; if (mem_err_o !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0b exp=1", mem_err_o); end
   endtask

   task automatic test_timeout_ready_wins();
      do_reset();
      em_memread_i = 1; mem_ready_i = 0;
      for (int i = 0; i < 14; i++) tick();
      mem_ready_i = 1;
      #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rw_stall got=%0b exp=0", stall_o); end
      tick();
      clr_inputs();
      #1;
      total++; if (mem_err_o !== 1'b0 || halt_o !== 1'b0) begin bad++; $display("FAIL rw_err err/halt got=%0b%0b exp=00", mem_err_o, halt_o); end
      total++; if (stall_cnt_o !== 16'd14) begin bad++; $display("FAIL rw_cnt got=%0d exp=14", stall_cnt_o); end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      em_memwrite_i = 1; mem_ready_i = 0;
      tick(); tick(); tick();
      rst_n_i = 0;
      #1;
      total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || flush_o !== 1'b1) begin bad++; $display("FAIL rm_forced req/stall/flush got=%0b%0b%0b exp=001", mem_req_o, stall_o, flush_o); end
      tick();
      rst_n_i = 1;
      em_memwrite_i = 0;
      #1;
      total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin bad++; $display("FAIL rm_idle req/stall got=%0b%0b exp=00", mem_req_o, stall_o); end
      total++; if (stall_cnt_o !== 16'd0 || mem_err_o !== 1'b0) begin bad++; $display("FAIL rm_regs cnt/err got=%0d/%0b exp=0/0", stall_cnt_o, mem_err_o); end
      em_memwrite_i = 1; mem_ready_i = 1;
      #1;
      total++; if (mem_req_o !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("FAIL rm_run req/stall got=%0b%0b exp=10", mem_req_o, stall_o); end
      tick();
      clr_inputs();
   endtask

   initial begin
      clr_inputs();
      rst_n_i = 0;
      test_reset();
      test_zero_wait();
      test_store_wait();
      test_forward();
      test_drain();
      test_done_with_wait();
      test_timeout();
      test_timeout_ready_wins();
      test_reset_mid_wait();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 4-stage 8-bit pipeline (IF, ID, EM, WB). It owns the global pipeline-register enables:
- freezes every stage while a data-memory access in EM is outstanding;
- computes EM-stage operand forwarding from the EM/WB register;
- bubbles the ID/EM register on drain;
- retires the machine cleanly once the done-marked instruction leaves WB.

It also counts stall cycles for performance debug.

Parameters:
MEM_TIMEOUT, 15, max cycles an EM memory access may wait for mem_ready_i before a fatal error (1..255)
DRAIN_CYCLES, 2, cycles from done seen in EM to halt (covers EM->WB commit)
CNT_W, 16, width of stall cycle counter

Ports:
clk_i  in  1  rising-edge clock
rst_n_i  in  1  synchronous active-low reset
em_memread_i  in  1  ID/EM register memread output (access in EM)
em_memwrite_i  in  1  ID/EM register memwrite output
em_done_i  in  1  ID/EM register done output
em_rs_addr_i  in  3  ID/EM rs address
em_rt_addr_i  in  3  ID/EM rt address
wb_regwrite_i  in  1  EM/WB regwrite
wb_write_addr_i  in  3  EM/WB destination address
mem_ready_i  in  1  data memory completes access this cycle
mem_req_o  out  1  data memory request strobe
stall_o  out  1  1 = hold PC, IF/ID, ID/EM, EM/WB (enables low)
flush_o  out  1  1 = ID/EM loads bubble (regwrite, memread, memwrite, CBwrite, done = 0)
fwd_rs_o  out  1  1 = EM rs operand from WB result
fwd_rt_o  out  1  1 = EM rt operand from WB result
halt_o  out  1  machine retired
mem_err_o  out  1  sticky memory timeout
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n_i=0 at posedge): state=RUN, wait_cnt=0, drain_cnt=0, halt_o=0, mem_err_o=0, stall_cnt_o=0.
- While rst_n_i is low, combinational outputs are forced: stall_o=0, flush_o=1, mem_req_o=0, fwd_*=0.
- Reset mid-access or mid-drain aborts it with no residual request.
- acc = em_memread_i | em_memwrite_i.
- States:
  - RUN:
    - mem_req_o = acc.
    - If acc & !mem_ready_i: stall_o=1, go to MEM_WAIT, wait_cnt=1.
    - If acc & mem_ready_i: zero-wait access, no stall.
    - If em_done_i and not stalling: go to DRAIN, drain_cnt=0.
  - MEM_WAIT:
    - mem_req_o=1, stall_o=1 (mem_req held stable until ready).
    - mem_ready_i=1: stall_o drops that same cycle and the pipeline advances at that edge. Go to RUN, or to DRAIN if em_done_i=1.
    - Otherwise wait_cnt++. When wait_cnt reaches MEM_TIMEOUT with no ready: mem_err_o=1, go to HALT.
  - DRAIN:
    - flush_o=1 every cycle, so nothing younger than done commits. stall_o=0, mem_req_o=0 (bubbles have acc=0).
    - drain_cnt++. When drain_cnt == DRAIN_CYCLES-1: go to HALT.
  - HALT:
    - stall_o=1, flush_o=1, halt_o=1 (registered, set on entry).
    - Exit only by reset.
- Forwarding (combinational, all states):
  - fwd_rs_o = wb_regwrite_i & (wb_write_addr_i == em_rs_addr_i).
  - fwd_rt_o is the same with rt.
  - Register 0 is not special.
- Simultaneous events:
  - done together with a waited access: the wait completes first, then DRAIN.
  - mem_ready_i in the same cycle the timeout would fire: ready wins, no error.
- stall_cnt_o: increments every cycle stall_o=1 outside HALT. Saturates at all-ones with no wrap.
- Latency: stall_o, flush_o, mem_req_o and fwd_* are combinational from state and inputs. halt_o and mem_err_o are registered (1 cycle after the qualifying edge).

Decomposition:
- Shared package pipe_pkg holds:
  - state enum RUN/MEM_WAIT/DRAIN/HALT (2 bits);
  - register-address width (3);
  - data width (8).
- One natural sub-module, fwd_unit: the pure-combinational rs/rt forwarding compare, reused if a second forwarding source is added later.
- FSM, counters and error logic stay in the top module.

Test Plan:
- Load with mem_ready_i=1 same cycle -> mem_req_o=1, stall_o=0, stall_cnt_o stays 0.
- Store with mem_ready_i low 3 cycles, then high -> stall_o=1 for exactly 3 cycles, mem_req_o held 4 cycles, stall_cnt_o=3, state returns to RUN.
- wb_regwrite_i=1, wb_write_addr_i=5, em_rs_addr_i=5, em_rt_addr_i=2 -> fwd_rs_o=1, fwd_rt_o=0. Then wb_regwrite_i=0 -> both 0.
- em_done_i pulse in RUN with DRAIN_CYCLES=2 -> flush_o=1 for 2 cycles, then halt_o=1, stall_o=1, held until rst_n_i=0.
- mem_ready_i never asserted with MEM_TIMEOUT=15 -> mem_err_o=1 and halt_o=1 after 15 wait cycles. Ready arriving on cycle 15 -> no error.
- rst_n_i=0 during MEM_WAIT -> next cycle state RUN, mem_req_o=0, stall_cnt_o=0, mem_err_o=0.
